// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and divider constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_MAX_WIDTH     = 16;

    // Quotient reported for a zero divisor; sliced down to the divider width.
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = {DIV_MAX_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference only if it is non-negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_r_next,
    output logic [WIDTH-1:0] o_q_next
);

    logic [WIDTH:0] w_trial;
    logic           w_fits;

    // Trial value is WIDTH+1 bits so the shifted remainder never overflows.
    // When it fits, the true difference is below 2^WIDTH, so a WIDTH-bit subtract is exact.
    always_comb begin
        w_trial  = {i_r, i_q[WIDTH-1]};
        w_fits   = (w_trial >= {1'b0, i_divisor});
        o_q_next = {i_q[WIDTH-2:0], w_fits};
        o_r_next = w_trial[WIDTH-1:0];
        if (w_fits) begin
            o_r_next = w_trial[WIDTH-1:0] - i_divisor;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// One quotient bit per clock; results hold until the next completed request.
module seq_restoring_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_dz;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r       (r_rem),
        .i_q       (r_q),
        .i_divisor (r_div),
        .o_r_next  (w_r_next),
        .o_q_next  (w_q_next)
    );

    assign w_last_step = (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; start only matters in IDLE.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = (i_divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                o_busy = 1'b1;
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture operands, iterate, and load results as DONE is entered
    // so they are already valid during the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem      <= '0;
            r_q        <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_divisor != '0) begin
                            r_q   <= i_dividend;
                            r_div <= i_divisor;
                            r_rem <= '0;
                            r_cnt <= CW'(WIDTH - 1);
                            r_dz  <= 1'b0;
                        end else begin
                            r_quot_out <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                            r_rem_out  <= i_dividend;
                            r_dz       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_next;
                    if (w_last_step) begin
                        r_quot_out <= w_q_next;
                        r_rem_out  <= w_r_next;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient    = r_quot_out;
    assign o_remainder   = r_rem_out;
    assign o_div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a request from IDLE; afterwards the bench sits in the cycle after the accepting edge
    // and the operand inputs are scrambled.
    task automatic push_and_start(input logic [W-1:0] a, input logic [W-1:0] b);
        sb.push_back(model(a, b));
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
    endtask

    // Counts cycles (1 = cycle after acceptance) until done, bounded, and busy samples seen.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (o_done !== 1'b1 && lat < 40) begin
            if (o_busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        if (o_busy === 1'b1) busy_cnt++;
    endtask

    task automatic test_reset;
        checks++;
        if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dz=%b, expected all 0",
                     o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
        end
    endtask

    task automatic test_basic;
        int lat, bc;
        exp_t e;
        push_and_start(8'd200, 8'd7);
        wait_done(lat, bc);
        e = sb.pop_front();
        checks++;
        if (lat !== 9) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 9", lat); end
        checks++;
        if (bc !== 9) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 9", bc); end
        checks++;
        if (o_quotient !== e.q || o_remainder !== e.r || o_div_by_zero !== e.dz) begin
            errors++;
            $display("[TB] FAIL basic_result: got %0d r %0d dz %b expected %0d r %0d dz %b",
                     o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.dz);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_after_done: got done=%b busy=%b expected 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        exp_t e;
        push_and_start(8'd255, 8'd1);
        wait_done(lat, bc);
        e = sb.pop_front();
        checks++;
        if (o_quotient !== e.q || o_remainder !== e.r) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %0d r %0d expected %0d r %0d", o_quotient, o_remainder, e.q, e.r);
        end
        // Raise start during DONE; it must wait for IDLE.
        sb.push_back(model(8'd5, 8'd9));
        i_dividend = 8'd5;
        i_divisor  = 8'd9;
        i_start    = 1'b1;
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_single_done: got done=%b busy=%b expected 0 0", o_done, o_busy);
        end
        tick();
        i_start = 1'b0;
        wait_done(lat, bc);
        e = sb.pop_front();
        checks++;
        if (lat !== 9) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 9", lat); end
        checks++;
        if (o_quotient !== e.q || o_remainder !== e.r) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %0d r %0d expected %0d r %0d", o_quotient, o_remainder, e.q, e.r);
        end
        tick();
        checks++;
        if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_pulse: got done=%b expected 0", o_done); end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        exp_t e;
        push_and_start(8'd100, 8'd0);
        wait_done(lat, bc);
        e = sb.pop_front();
        checks++;
        if (lat !== 1) begin errors++; $display("[TB] FAIL dz_latency: got %0d expected 1", lat); end
        checks++;
        if (o_quotient !== e.q || o_remainder !== e.r || o_div_by_zero !== e.dz) begin
            errors++;
            $display("[TB] FAIL dz_result: got %0d r %0d dz %b expected %0d r %0d dz %b",
                     o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.dz);
        end
        tick();
        push_and_start(8'd10, 8'd3);
        checks++;
        if (o_div_by_zero !== 1'b0 || o_quotient !== 8'd255) begin
            errors++;
            $display("[TB] FAIL dz_clear_hold: got dz=%b q=%0d expected dz=0 q=255", o_div_by_zero, o_quotient);
        end
        wait_done(lat, bc);
        e = sb.pop_front();
        checks++;
        if (lat !== 9 || o_quotient !== e.q || o_remainder !== e.r || o_div_by_zero !== e.dz) begin
            errors++;
            $display("[TB] FAIL dz_followup: got lat %0d %0d r %0d dz %b expected lat 9 %0d r %0d dz %b",
                     lat, o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.dz);
        end
        tick();
    endtask

    task automatic test_ignore_start;
        int   dones;
        int   lat;
        exp_t e;
        dones = 0;
        lat   = 0;
        push_and_start(8'd200, 8'd7);
        for (int c = 1; c <= 20; c++) begin
            if (o_done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    lat = c;
                    e   = sb.pop_front();
                    checks++;
                    if (o_quotient !== e.q || o_remainder !== e.r) begin
                        errors++;
                        $display("[TB] FAIL ignore_result: got %0d r %0d expected %0d r %0d",
                                 o_quotient, o_remainder, e.q, e.r);
                    end
                end
            end
            i_start    = (c == 3 || c == 6);
            i_dividend = 8'd9;
            i_divisor  = 8'd3;
            tick();
        end
        i_start = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        checks++;
        if (dones !== 1 || lat !== 9) begin
            errors++;
            $display("[TB] FAIL ignore_done_count: got %0d dones at %0d expected 1 at 9", dones, lat);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc, dones;
        exp_t e;
        push_and_start(8'd200, 8'd7);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        checks++;
        if ({o_busy, o_done, o_quotient, o_remainder, o_div_by_zero} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                     o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
        end
        tick();
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (o_done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin errors++; $display("[TB] FAIL reset_mid_no_done: got %0d dones expected 0", dones); end
        push_and_start(8'd50, 8'd6);
        wait_done(lat, bc);
        e = sb.pop_front();
        checks++;
        if (o_quotient !== e.q || o_remainder !== e.r) begin
            errors++;
            $display("[TB] FAIL reset_mid_followup: got %0d r %0d expected %0d r %0d", o_quotient, o_remainder, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_random;
        int           lat, bc;
        int           prod;
        exp_t         e;
        logic [W-1:0] a, b;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            push_and_start(a, b);
            wait_done(lat, bc);
            e    = sb.pop_front();
            prod = int'(o_quotient) * int'(b) + int'(o_remainder);
            checks++;
            if (prod != int'(a) || o_remainder >= b || lat != 9) begin
                errors++;
                $display("[TB] FAIL random_invariant: %0d/%0d got q %0d r %0d lat %0d",
                         a, b, o_quotient, o_remainder, lat);
            end
            checks++;
            if (o_quotient !== e.q || o_remainder !== e.r || o_div_by_zero !== 1'b0) begin
                errors++;
                $display("[TB] FAIL random_scoreboard: %0d/%0d got %0d r %0d expected %0d r %0d",
                         a, b, o_quotient, o_remainder, e.q, e.r);
            end
            tick();
        end
    endtask

    // Test sequence.
    initial begin
        rst        = 1'b1;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
